lsu_subword: RTL and testbench

//  Load/store sub-word adapter placed directly upstream of the word-addressed data memory.

---
 rtl/lsu_subword.sv | 192 +++++++++++++++++++
 tb/tb_lsu_subword.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_subword.sv
// Load/store sub-word adapter in front of a word-addressed data memory.
// It takes byte, half and word loads and stores and talks to the memory's
// word-only port. Loads are sign- or zero-extended. Byte and half stores do
// a read-modify-write. Misaligned and out-of-range requests get an error
// response and never reach the memory.
module lsu_subword #(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic        resp_oob,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MERGE,
        S_WRITE,
        S_RESP
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t      r_state;
    state_t      w_next;

    // Request fields are latched at acceptance, so the requester may change its inputs afterwards.
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_merged;

    // The response registers hold their values until the next response.
    logic [31:0] r_rdata;
    logic        r_misaligned;
    logic        r_oob;

    logic        w_misaligned;
    logic        w_oob;
    logic        w_error;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [31:0] w_merged;

    // Classify the incoming request. The size=11 encoding is reported as misaligned.
    // Misalignment and range are checked separately, so a request can set both flags.
    assign w_misaligned = (req_size == 2'b11)
                       || ((req_size == SZ_HALF) && req_addr[0])
                       || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    assign w_oob        = (req_addr[31:2] >= 30'(MEM_WORDS));
    assign w_error      = w_misaligned || w_oob;

    // Extract the addressed lane from the memory word and extend it to 32 bits.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it
        // unassigned and no latch is inferred.
        w_byte      = mem_rd[{r_addr[1:0], 3'b000} +: 8];
        w_half      = mem_rd[{r_addr[1], 4'b0000} +: 16];
        w_load_data = mem_rd;
        case (r_size)
            SZ_BYTE: w_load_data = {{24{~r_unsigned & w_byte[7]}}, w_byte};
            SZ_HALF: w_load_data = {{16{~r_unsigned & w_half[15]}}, w_half};
            default: w_load_data = mem_rd;
        endcase
    end

    // Replace only the addressed byte or half of the current memory word.
    always_comb begin
        w_merged = mem_rd;
        case (r_size)
            SZ_BYTE: w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
            SZ_HALF: w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
            default: w_merged = mem_rd;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every flop samples
        // values from before the clock edge, whatever order the blocks run in.
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and the memory/handshake outputs decoded from the state.
    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_we     = 1'b0;
        mem_a      = {r_addr[31:2], 2'b00};
        mem_wd     = 32'h0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                mem_a     = 32'h0;
                if (req_valid) begin
                    if (w_error) begin
                        w_next = S_RESP;
                    end else if (!req_we) begin
                        w_next = S_LOAD;
                    end else if (req_size == SZ_WORD) begin
                        w_next = S_WRITE;
                    end else begin
                        w_next = S_MERGE;
                    end
                end
            end
            S_LOAD:  w_next = S_RESP;
            S_MERGE: w_next = S_WRITE;
            S_WRITE: begin
                // A synchronous reset in this cycle must not commit the write.
                mem_we = ~reset;
                mem_wd = (r_size == SZ_WORD) ? r_wdata : r_merged;
                w_next = S_RESP;
            end
            S_RESP: begin
                resp_valid = ~reset;
                w_next     = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Request latches, the merge buffer and the response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_size       <= 2'b00;
            r_unsigned   <= 1'b0;
            r_addr       <= 32'h0;
            r_wdata      <= 32'h0;
            r_merged     <= 32'h0;
            r_rdata      <= 32'h0;
            r_misaligned <= 1'b0;
            r_oob        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_addr     <= req_addr;
                        r_wdata    <= req_wdata;
                        if (w_error) begin
                            r_rdata      <= 32'h0;
                            r_misaligned <= w_misaligned;
                            r_oob        <= w_oob;
                        end
                    end
                end
                S_LOAD: begin
                    r_rdata      <= w_load_data;
                    r_misaligned <= 1'b0;
                    r_oob        <= 1'b0;
                end
                S_MERGE: r_merged <= w_merged;
                S_WRITE: begin
                    r_rdata      <= 32'h0;
                    r_misaligned <= 1'b0;
                    r_oob        <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign resp_rdata      = r_rdata;
    assign resp_misaligned = r_misaligned;
    assign resp_oob        = r_oob;

endmodule

// File: tb/tb_lsu_subword.sv
// Self-checking bench for lsu_subword. It uses a behavioural 256-word memory,
// a table of request vectors, a response scoreboard, and a hand-written
// sequence that asserts reset during a write.
module tb_lsu_subword;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic        resp_oob;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    lsu_subword #(.MEM_WORDS(256)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_we          (req_we),
        .req_size        (req_size),
        .req_unsigned    (req_unsigned),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_misaligned (resp_misaligned),
        .resp_oob        (resp_oob),
        .mem_we          (mem_we),
        .mem_a           (mem_a),
        .mem_wd          (mem_wd),
        .mem_rd          (mem_rd)
    );

    always #5 clk = ~clk;

    // Behavioural memory. The bench preloads words through its own write port.
    logic [31:0] mem [256] = '{default: 32'h0};
    logic        tb_we = 1'b0;
    logic [7:0]  tb_idx = 8'h0;
    logic [31:0] tb_data = 32'h0;
    int          wr_cnt = 0;
    logic [31:0] last_wd = 32'h0;

    assign mem_rd = (mem_a[31:2] < 30'd256) ? mem[mem_a[9:2]] : 32'h0;

    // Memory write port: DUT writes first, preload writes otherwise.
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_a[9:2]] <= mem_wd;
            wr_cnt          <= wr_cnt + 1;
            last_wd         <= mem_wd;
        end else if (tb_we) begin
            mem[tb_idx] <= tb_data;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_mis;
        logic        exp_oob;
        int          exp_lat;
        int          exp_wr;
        logic [31:0] exp_wd;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        oob;
        int          idx;
    } exp_t;

    vec_t vq[$];
    exp_t sb[$];

    // Scoreboard: every response pops the oldest expectation and compares against it.
    always @(negedge clk) begin
        if (resp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check($sformatf("v%0d_rdata", e.idx), resp_rdata, e.rdata);
                check($sformatf("v%0d_mis", e.idx), {31'h0, resp_misaligned}, {31'h0, e.mis});
                check($sformatf("v%0d_oob", e.idx), {31'h0, resp_oob}, {31'h0, e.oob});
            end
        end
    end

    task automatic preload(input int idx, input logic [31:0] data);
        @(negedge clk);
        tb_we   = 1'b1;
        tb_idx  = idx[7:0];
        tb_data = data;
        @(negedge clk);
        tb_we   = 1'b0;
    endtask

    // Issue one table vector. After acceptance the inputs are scrambled, which
    // confirms that the request is latched.
    task automatic run_vec(input int i);
        vec_t v;
        int   waits;
        int   lat;
        int   wr0;
        v = vq[i];
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = v.we;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        waits = 0;
        while (!req_ready && waits < 8) begin
            @(negedge clk);
            waits++;
        end
        if (!req_ready) check($sformatf("v%0d_ready", i), 32'd0, 32'd1);
        wr0 = wr_cnt;
        sb.push_back('{v.exp_rdata, v.exp_mis, v.exp_oob, i});
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_we       = ~v.we;
        req_size     = 2'($urandom_range(0, 3));
        req_unsigned = ~v.uns;
        req_addr     = $urandom;
        req_wdata    = $urandom;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 8);
        check($sformatf("v%0d_latency", i), lat, v.exp_lat);
        check($sformatf("v%0d_writes", i), wr_cnt - wr0, v.exp_wr);
        if (v.exp_wr != 0) check($sformatf("v%0d_wd", i), last_wd, v.exp_wd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //          we    size   uns   addr        wdata         rdata         mis   oob   lat wr wd
        vq.push_back('{1'b0, 2'b00, 1'b0, 32'h003, 32'h0,        32'hFFFFFF88, 1'b0, 1'b0, 2, 0, 32'h0});        // LB
        vq.push_back('{1'b0, 2'b00, 1'b1, 32'h003, 32'h0,        32'h00000088, 1'b0, 1'b0, 2, 0, 32'h0});        // LBU
        vq.push_back('{1'b0, 2'b01, 1'b0, 32'h002, 32'h0,        32'hFFFF8899, 1'b0, 1'b0, 2, 0, 32'h0});        // LH upper
        vq.push_back('{1'b0, 2'b01, 1'b1, 32'h000, 32'h0,        32'h0000AABB, 1'b0, 1'b0, 2, 0, 32'h0});        // LHU lower
        vq.push_back('{1'b0, 2'b00, 1'b0, 32'h000, 32'h0,        32'hFFFFFFBB, 1'b0, 1'b0, 2, 0, 32'h0});        // LB lane0
        vq.push_back('{1'b1, 2'b00, 1'b0, 32'h001, 32'h12345677, 32'h0,        1'b0, 1'b0, 3, 1, 32'h889977BB}); // SB
        vq.push_back('{1'b0, 2'b10, 1'b0, 32'h000, 32'h0,        32'h889977BB, 1'b0, 1'b0, 2, 0, 32'h0});        // LW
        vq.push_back('{1'b1, 2'b01, 1'b0, 32'h016, 32'h0000BEEF, 32'h0,        1'b0, 1'b0, 3, 1, 32'hBEEF0000}); // SH
        vq.push_back('{1'b0, 2'b01, 1'b0, 32'h016, 32'h0,        32'hFFFFBEEF, 1'b0, 1'b0, 2, 0, 32'h0});        // LH
        vq.push_back('{1'b0, 2'b10, 1'b1, 32'h014, 32'h0,        32'hBEEF0000, 1'b0, 1'b0, 2, 0, 32'h0});        // LW word5
        vq.push_back('{1'b0, 2'b10, 1'b0, 32'h002, 32'h0,        32'h0,        1'b1, 1'b0, 1, 0, 32'h0});        // LW misaligned
        vq.push_back('{1'b1, 2'b01, 1'b0, 32'h001, 32'hFFFF,     32'h0,        1'b1, 1'b0, 1, 0, 32'h0});        // SH misaligned
        vq.push_back('{1'b0, 2'b11, 1'b0, 32'h000, 32'h0,        32'h0,        1'b1, 1'b0, 1, 0, 32'h0});        // illegal size
        vq.push_back('{1'b1, 2'b10, 1'b0, 32'h400, 32'h55555555, 32'h0,        1'b0, 1'b1, 1, 0, 32'h0});        // SW oob
        vq.push_back('{1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0,        32'hCAFEF00D, 1'b0, 1'b0, 2, 0, 32'h0});        // LW last word
        vq.push_back('{1'b1, 2'b10, 1'b0, 32'h010, 32'h01020304, 32'h0,        1'b0, 1'b0, 2, 1, 32'h01020304}); // SW
        vq.push_back('{1'b0, 2'b10, 1'b0, 32'h010, 32'h0,        32'h01020304, 1'b0, 1'b0, 2, 0, 32'h0});        // LW back
        vq.push_back('{1'b0, 2'b10, 1'b0, 32'h402, 32'h0,        32'h0,        1'b1, 1'b1, 1, 0, 32'h0});        // mis + oob
        vq.push_back('{1'b1, 2'b00, 1'b0, 32'h403, 32'hAB,       32'h0,        1'b0, 1'b1, 1, 0, 32'h0});        // SB oob

        reset        = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        preload(0,   32'h8899AABB);
        preload(2,   32'h11112222);
        preload(255, 32'hCAFEF00D);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_flags", {30'h0, resp_misaligned, resp_oob}, 32'h0);
        check("rst_mem_we", {31'h0, mem_we}, 32'h0);
        check("rst_mem_a", mem_a, 32'h0);
        check("rst_req_ready", {31'h0, req_ready}, 32'h1);

        foreach (vq[i]) run_vec(i);

        check("mem_word0", mem[0], 32'h889977BB);
        check("mem_word5", mem[5], 32'hBEEF0000);
        check("mem_word4", mem[4], 32'h01020304);

        // Reset asserted while a word store is in WRITE: the write and the response are both dropped.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h008;
        req_wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset     = 1'b1;
        #1;
        check("rst_write_mem_we", {31'h0, mem_we}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rst_write_ready", {31'h0, req_ready}, 32'h1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("rst_write_no_resp%0d", k), {31'h0, resp_valid}, 32'h0);
        end
        check("rst_write_word2", mem[2], 32'h11112222);
        check("sb_empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
